// File: rtl/window_row_buffer_pkg.sv
// Shared configuration for the window row buffer.
// Holds the default sample width, row width and window height (the window
// height tracks the MAC convolution height), plus the FSM state encodings
// used by window_row_buffer.
package window_row_buffer_pkg;

  // Convolution height of the MAC array; the window must match it.
  localparam int MAC_CN_HGT   = 9;
  localparam int BB_WIDTH_DEF = 40;
  localparam int FXP_DEF      = 8;
  localparam int WIN_H_DEF    = MAC_CN_HGT;

  // FSM state encodings.
  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  typedef enum logic [1:0] {
    S_FILL = ST_FILL,  // fewer than WIN_H rows committed since frame start
    S_HOLD = ST_HOLD,  // window presented, BB_OUT frozen
    S_PEND = ST_PEND   // window released, waiting for the next full row
  } wbuf_state_e;

endpackage

// File: rtl/wbuf_row_stage.sv
// Staging row for the window row buffer.
// Collects BB_WIDTH raster samples, tracks the write column and flags when
// the row is complete and waiting to be committed.
// Ports:
//   clk, srst       clock and synchronous active-high reset
//   clr             start-of-frame: empty the row, column back to 0
//   pix, accept     sample and its write strobe (written at the current column)
//   commit          the parent copies the row out this cycle
//   full            BB_WIDTH samples held and not yet committed
//   last            current column is BB_WIDTH-1
//   row             stored row, column c at bits [c*FXP +: FXP]
//   row_byp         stored row with pix in the last column, for committing
//                   a row on the same edge its final sample arrives
module wbuf_row_stage #(
  parameter int FXP      = 8,
  parameter int BB_WIDTH = 40
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    clr,
  input  logic [FXP-1:0]          pix,
  input  logic                    accept,
  input  logic                    commit,
  output logic                    full,
  output logic                    last,
  output logic [BB_WIDTH*FXP-1:0] row,
  output logic [BB_WIDTH*FXP-1:0] row_byp
);

  localparam int COL_W = $clog2(BB_WIDTH);

  logic [COL_W-1:0] col_q, col_d;
  logic             full_q, full_d;
  logic [FXP-1:0]   data_q [BB_WIDTH];

  assign last = (col_q == COL_W'(BB_WIDTH - 1));
  assign full = full_q;

  always_comb begin
    col_d  = col_q;
    // A row completes on the last-column write and stays full until a
    // commit; a commit in the same cycle as completion empties it at once.
    full_d = (full_q || (accept && last)) && !commit;
    if (accept) begin
      col_d = last ? '0 : col_q + 1'b1;
    end
    if (clr) begin
      col_d  = '0;
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      col_q  <= '0;
      full_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      full_q <= full_d;
    end
  end

  // Sample storage has no reset: a row is only ever committed after every
  // column has been rewritten since the last clear, so old contents never leak.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[col_q] <= pix;
    end
  end

  for (genvar gi = 0; gi < BB_WIDTH; gi++) begin : g_pack
    assign row[gi*FXP +: FXP] = data_q[gi];
    if (gi == BB_WIDTH - 1) begin : g_byp_last
      assign row_byp[gi*FXP +: FXP] = pix;
    end else begin : g_byp_col
      assign row_byp[gi*FXP +: FXP] = data_q[gi];
    end
  end

endmodule

// File: rtl/window_row_buffer.sv
// Window row buffer: turns a raster stream into a WIN_H-row window for the
// MAC array.
// Ports:
//   CLK, RST         clock, synchronous active-high reset (priority over SOF)
//   SOF              start of frame: discard buffered rows, refill from scratch
//   PIX_IN/_VALID/_READY   raster input handshake
//   BB_OUT           window, sample (row j, col c) at [(j*BB_WIDTH+c)*FXP +: FXP],
//                    row 0 oldest
//   BB_VALID         BB_OUT holds a complete window
//   BB_READY         consumer releases the current window
//   STALL_CNT        (only with WINBUF_STALL_CNT_EN defined) saturating count of
//                    cycles where PIX_IN_VALID=1 and PIX_IN_READY=0
// Optional feature macro: WINBUF_STALL_CNT_EN.
module window_row_buffer
  import window_row_buffer_pkg::*;
#(
  parameter int FXP      = FXP_DEF,
  parameter int BB_WIDTH = BB_WIDTH_DEF,
  parameter int WIN_H    = WIN_H_DEF
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          SOF,
  input  logic [FXP-1:0]                PIX_IN,
  input  logic                          PIX_IN_VALID,
  output logic                          PIX_IN_READY,
  output logic [WIN_H*BB_WIDTH*FXP-1:0] BB_OUT,
  output logic                          BB_VALID,
  input  logic                          BB_READY
`ifdef WINBUF_STALL_CNT_EN
  ,
  output logic [15:0]                   STALL_CNT
`endif
);

  localparam int ROW_W = BB_WIDTH * FXP;
  localparam int WIN_W = WIN_H * ROW_W;
  localparam int CNT_W = $clog2(WIN_H + 1);

  wbuf_state_e      state_q, state_d;
  logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [WIN_W-1:0] rows_q, rows_d;
  logic             bb_valid_q, bb_valid_d;

  logic             stage_full, stage_last;
  logic [ROW_W-1:0] stage_row, stage_row_byp;
  logic             commit_ok, accept, commit_stored, commit_byp, commit;

  // A commit may happen whenever no window is being held, or the consumer
  // releases the held one.
  assign commit_ok     = (state_q != S_HOLD) || BB_READY;
  assign PIX_IN_READY  = !stage_full || commit_ok;
  assign accept        = PIX_IN_VALID && PIX_IN_READY && !SOF;
  assign commit_stored = stage_full && commit_ok && !SOF;
  // Outside HOLD the completing sample is merged in directly so the row
  // commits on the same edge it fills; this gives BB_VALID one cycle after
  // the final sample of a window.
  assign commit_byp    = accept && stage_last && !stage_full && (state_q != S_HOLD);
  assign commit        = commit_stored || commit_byp;

  wbuf_row_stage #(
    .FXP      (FXP),
    .BB_WIDTH (BB_WIDTH)
  ) u_stage (
    .clk     (CLK),
    .srst    (RST),
    .clr     (SOF),
    .pix     (PIX_IN),
    .accept  (accept),
    .commit  (commit),
    .full    (stage_full),
    .last    (stage_last),
    .row     (stage_row),
    .row_byp (stage_row_byp)
  );

  always_comb begin
    rows_d = rows_q;
    if (commit) begin
      // Oldest row drops out of the low end, the new row enters at the top.
      rows_d = {(stage_full ? stage_row : stage_row_byp), rows_q[WIN_W-1:ROW_W]};
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (SOF) begin
      state_d    = S_FILL;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (commit) begin
            if (fill_cnt_q == CNT_W'(WIN_H - 1)) begin
              fill_cnt_d = CNT_W'(WIN_H);
              state_d    = S_HOLD;
            end else begin
              fill_cnt_d = fill_cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Release with a full staging row shifts in place and stays in HOLD.
          if (BB_READY && !stage_full) begin
            state_d = S_PEND;
          end
        end
        S_PEND: begin
          if (commit) begin
            state_d = S_HOLD;
          end
        end
        default: state_d = S_FILL;
      endcase
    end
    bb_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_FILL;
      fill_cnt_q <= '0;
      rows_q     <= '0;
      bb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      rows_q     <= rows_d;
      bb_valid_q <= bb_valid_d;
    end
  end

  assign BB_OUT   = rows_q;
  assign BB_VALID = bb_valid_q;

`ifdef WINBUF_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (SOF) begin
      stall_cnt_d = '0;
    end else if (PIX_IN_VALID && !PIX_IN_READY && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_window_row_buffer.sv
// Bench for window_row_buffer: directed stimulus pushes the expected window
// (arrival cycle and corner samples) into a scoreboard queue; a monitor pops
// and compares whenever a new window appears on BB_OUT with BB_VALID high.
module tb_window_row_buffer;
  import window_row_buffer_pkg::*;

  localparam int FXP = 8;
  localparam int BW  = 40;
  localparam int WH  = 9;
  localparam int WW  = WH * BW * FXP;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SOF = 1'b0;
  logic [7:0]    PIX_IN = '0;
  logic          PIX_IN_VALID = 1'b0;
  logic          BB_READY = 1'b0;
  logic          PIX_IN_READY;
  logic [WW-1:0] BB_OUT;
  logic          BB_VALID;
`ifdef WINBUF_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  window_row_buffer #(
    .FXP      (FXP),
    .BB_WIDTH (BW),
    .WIN_H    (WH)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SOF          (SOF),
    .PIX_IN       (PIX_IN),
    .PIX_IN_VALID (PIX_IN_VALID),
    .PIX_IN_READY (PIX_IN_READY),
    .BB_OUT       (BB_OUT),
    .BB_VALID     (BB_VALID),
    .BB_READY     (BB_READY)
`ifdef WINBUF_STALL_CNT_EN
    ,
    .STALL_CNT    (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;
  int last_xfer = 0;

  typedef struct {
    int         cyc;
    logic [7:0] r0c0;
    logic [7:0] r0c39;
    logic [7:0] r8c0;
    logic [7:0] r8c39;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  function automatic logic [7:0] px(input int j, input int c);
    return BB_OUT[(j*BW + c)*FXP +: FXP];
  endfunction

  function automatic void push(input int c, input int a, input int b, input int d, input int f);
    exp_t e;
    e.cyc   = c;
    e.r0c0  = 8'(a);
    e.r0c39 = 8'(b);
    e.r8c0  = 8'(d);
    e.r8c39 = 8'(f);
    exp_q.push_back(e);
  endfunction

  // Monitor: a window event is BB_VALID rising or BB_OUT changing while valid.
  logic          prev_v = 1'b0;
  logic [WW-1:0] prev_out = '0;
  exp_t          mon_e;
  always @(negedge CLK) begin
    if (!RST && BB_VALID && (!prev_v || BB_OUT !== prev_out)) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_window: window at cycle %0d, required none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("win_cycle", cyc, mon_e.cyc);
        check("win_r0c0", px(0, 0), mon_e.r0c0);
        check("win_r0c39", px(0, 39), mon_e.r0c39);
        check("win_r8c0", px(8, 0), mon_e.r8c0);
        check("win_r8c39", px(8, 39), mon_e.r8c39);
        $display("window at cycle %0d: r0c0=%0d r8c39=%0d", cyc, px(0, 0), px(8, 39));
      end
    end
    prev_v   <= BB_VALID;
    prev_out <= BB_OUT;
  end

  // Offer one sample; returns one time unit after the edge that took it.
  task automatic send(input logic [7:0] v);
    int waits;
    waits = 0;
    PIX_IN = v;
    PIX_IN_VALID = 1'b1;
    @(negedge CLK);
    while (!PIX_IN_READY && waits < 100) begin
      waits++;
      @(negedge CLK);
    end
    if (!PIX_IN_READY) begin
      checks++;
      $display("FAIL send_timeout: ready low for %0d cycles, required accept", waits);
    end
    last_xfer = cyc + 1;
    @(posedge CLK);
    #1;
    PIX_IN_VALID = 1'b0;
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) send(8'((base + i) % 256));
  endtask

  task automatic check_reset_state();
    check("rst_bb_valid", BB_VALID, 0);
    check("rst_pix_ready", PIX_IN_READY, 1);
    check("rst_bb_out_nonzero", |BB_OUT, 0);
`ifdef WINBUF_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_state();

    // First window: values = index, latency one cycle after sample 359.
    stream(359, 0);
    check("fill_valid_early", BB_VALID, 0);
    send(8'(359));
    push(last_xfer, 0, 39, 64, 103);

    // Held window: 40 samples fill staging, the 41st stalls.
    stream(40, 360);
    check("hold_valid", BB_VALID, 1);
    PIX_IN = 8'(400);
    PIX_IN_VALID = 1'b1;
    repeat (5) @(posedge CLK);
    @(negedge CLK);
    check("stall_ready", PIX_IN_READY, 0);
    check("stall_bb_out", px(8, 39), 103);
`ifdef WINBUF_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 5);
`endif

    // Release with a full staging row: shift in place, stalled beat accepted.
    @(posedge CLK);
    #1;
    BB_READY = 1'b1;
    @(negedge CLK);
    check("release_ready", PIX_IN_READY, 1);
    push(cyc + 1, 40, 79, 104, 143);
    @(posedge CLK);
    #1;
    BB_READY = 1'b0;
    PIX_IN_VALID = 1'b0;
    check("shift_valid", BB_VALID, 1);

    // Release with 10 staged samples: PEND until 30 more arrive.
    stream(9, 401);
    BB_READY = 1'b1;
    @(posedge CLK);
    #1;
    BB_READY = 1'b0;
    check("pend_valid", BB_VALID, 0);
    stream(29, 410);
    check("pend_valid_late", BB_VALID, 0);
    send(8'(439));
    push(last_xfer, 80, 119, 144, 183);

    // SOF in HOLD with a simultaneous beat: beat dropped, full refill needed.
    SOF = 1'b1;
    PIX_IN = 8'hAA;
    PIX_IN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    SOF = 1'b0;
    PIX_IN_VALID = 1'b0;
    check("sof_valid", BB_VALID, 0);
    check("sof_ready", PIX_IN_READY, 1);
`ifdef WINBUF_STALL_CNT_EN
    check("sof_stall_cnt", stall_cnt, 0);
`endif
    stream(359, 100);
    check("sof_valid_early", BB_VALID, 0);
    send(8'(459));
    push(last_xfer, 100, 139, 164, 203);

    // RST after 200 samples of a fresh frame.
    SOF = 1'b1;
    @(posedge CLK);
    #1;
    SOF = 1'b0;
    stream(200, 7);
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    check_reset_state();
    stream(359, 30);
    check("rst_valid_early", BB_VALID, 0);
    send(8'(389));
    push(last_xfer, 30, 69, 94, 133);

    repeat (3) @(negedge CLK);
    check("pending_windows", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/window_row_buffer.md
WINDOW_ROW_BUFFER -- requirements
Module: window_row_buffer

Interface
REQ-001 Parameter: FXP, 8, bit width of one fixed-point sample.
REQ-002 Parameter: BB_WIDTH, 40, samples per buffered row.
REQ-003 Parameter: WIN_H, 9, rows held in the window; equals the MAC convolution height.
REQ-004 Port: CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 Port: RST  in  1  reset; synchronous and active-high.
REQ-006 Port: SOF  in  1  start-of-frame pulse; discards buffered rows.
REQ-007 Port: PIX_IN  in  FXP  raster-order input sample.
REQ-008 Port: PIX_IN_VALID  in  1  PIX_IN valid.
REQ-009 Port: PIX_IN_READY  out  1  block accepts PIX_IN this cycle.
REQ-010 Port: BB_OUT  out  WIN_H*BB_WIDTH*FXP  window; sample (row j, col c) at bits [(j*BB_WIDTH+c)*FXP +: FXP], row 0 oldest.
REQ-011 Port: BB_VALID  out  1  BB_OUT holds a complete WIN_H-row window.
REQ-012 Port: BB_READY  in  1  downstream consumer releases the current window.

Function
REQ-013 Sample transfer occurs only when PIX_IN_VALID and PIX_IN_READY are both high in the same cycle.
REQ-014 Accepted samples fill a staging row, column counter COL 0..BB_WIDTH-1, and COL wraps to 0 after BB_WIDTH-1.
REQ-015 Staging row full = BB_WIDTH samples accepted and not yet committed.
REQ-016 Commit: row j <= row j+1 for j < WIN_H-1, row WIN_H-1 <= staging row, staging emptied, all in one cycle.
REQ-017 FILL_CNT counts committed rows, saturating at WIN_H.
REQ-018 States: FILL (FILL_CNT < WIN_H), HOLD (BB_VALID=1), PEND (window released, waiting for next row).
REQ-019 FILL: a full staging row commits immediately; the commit that makes FILL_CNT reach WIN_H moves the FSM to HOLD.
REQ-020 HOLD: BB_VALID=1 and BB_OUT stable; the staging row keeps filling but does not commit.
REQ-021 HOLD with BB_READY=1 and staging full: commit in the same cycle; stay in HOLD; the new window is valid on the next cycle.
REQ-022 HOLD with BB_READY=1 and staging not full: go to PEND with BB_VALID=0.
REQ-023 PEND: commit when the staging row becomes full, then go to HOLD.
REQ-024 PIX_IN_READY = !(staging full and commit blocked); a full staging row with no commit in the current cycle back-pressures the input.
REQ-025 A sample accepted in the same cycle as its row's commit is the first sample of the next staging row (COL=0).
REQ-026 SOF: FILL_CNT<=0, COL<=0, staging emptied, state FILL, BB_VALID<=0.
REQ-027 SOF has priority over a simultaneous PIX_IN transfer, which is dropped.
REQ-028 SOF does not clear the row data; stale rows are never flagged valid.
REQ-029 Latency: BB_VALID rises on the cycle after the WIN_H*BB_WIDTH-th accepted sample.

Reset
REQ-030 RST has priority over SOF.
REQ-031 RST drives: BB_VALID=0, PIX_IN_READY=1 on the following cycle, all row data and BB_OUT=0, FILL_CNT=0, COL=0, state FILL.
REQ-032 RST mid-row or mid-window discards all partial data, and no window is presented afterwards without WIN_H fresh rows.

Configuration
REQ-033 The macro WINBUF_STALL_CNT_EN, when defined, adds output STALL_CNT (16 bits).
REQ-034 STALL_CNT counts cycles with PIX_IN_VALID=1 and PIX_IN_READY=0, saturates at 16'hFFFF, and is cleared by RST or SOF.
REQ-035 Without WINBUF_STALL_CNT_EN, the STALL_CNT port and its counter are absent and behaviour is otherwise identical.

Structure
REQ-036 FXP, BB_WIDTH and WIN_H defaults come from the shared configuration header, consistent with MAC_CN_HGT and BB_WIDTH.
REQ-037 FSM state encodings are defined as constants in the shared header.
REQ-038 A sub-module wbuf_row_stage holds the staging row and COL counter and exports a full flag; the top level holds the row array and the FSM.

Verification
REQ-039 Stream 360 samples with value = index, BB_READY=0: BB_VALID rises the cycle after sample 359; BB_OUT row 0 col 0 = 0; row 8 col 39 = 359 (mod 2^FXP).
REQ-040 Hold BB_READY=0 and stream 41 more samples: the 41st stalls (PIX_IN_READY=0) and BB_OUT is unchanged; with the macro, STALL_CNT increments each stalled cycle.
REQ-041 Pulse BB_READY when the staging row is full: a one-row shift happens in the same cycle, BB_VALID stays 1, and new row 0 = old row 1.
REQ-042 Pulse BB_READY with 10 staged samples: BB_VALID=0 (PEND) until 30 more samples arrive, then BB_VALID=1.
REQ-043 Assert SOF in HOLD with a simultaneous PIX_IN beat: the beat is dropped, BB_VALID=0, and 360 new samples are required before BB_VALID.
REQ-044 Assert RST after 200 samples: outputs return to reset values, and 360 new samples produce a window containing only post-reset data.
